// File: rtl/count_seq_checker.sv
// ============================================================================
// Module      : count_seq_checker
// Description : Observes an up/down counter, predicts each next value with
//               modular +/-1 arithmetic, locks after a run of correct steps
//               and counts (saturating) every mismatch seen while locked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    input  logic             dir_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_q
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       c_lock_tgt = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] c_err_max  = '1;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   prev_val_q,  prev_val_d;
    logic               prev_dir_q,  prev_dir_d;
    logic [3:0]         match_cnt_q, match_cnt_d;
    logic               locked_q,    locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [WIDTH-1:0]   last_val_q,  last_val_d;

    logic [WIDTH-1:0]   w_exp;
    logic               w_match;
    logic [3:0]         w_match_inc;

    // Prediction always uses the direction captured with the previous sample,
    // so a direction change on the current sample is never an error.
    assign w_exp       = prev_dir_q ? (prev_val_q - WIDTH'(1)) : (prev_val_q + WIDTH'(1));
    assign w_match     = (q_in == w_exp);
    assign w_match_inc = match_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        prev_val_d  = prev_val_q;
        prev_dir_d  = prev_dir_q;
        match_cnt_d = match_cnt_q;
        err_count_d = err_count_q;
        last_val_d  = last_val_q;
        err_pulse_d = 1'b0;

        // Clear is applied before any increment in the same cycle.
        if (clr_err) begin
            err_count_d = '0;
        end

        if (en) begin
            prev_val_d = q_in;
            prev_dir_d = dir_in;
            last_val_d = q_in;

            case (state_q)
                ST_IDLE: begin
                    match_cnt_d = 4'd0;
                    state_d     = ST_SYNC;
                end
                ST_SYNC: begin
                    if (w_match) begin
                        match_cnt_d = w_match_inc;
                        if (w_match_inc == c_lock_tgt) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_cnt_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_match) begin
                        err_pulse_d = 1'b1;
                        if (err_count_d != c_err_max) begin
                            err_count_d = err_count_d + ERR_W'(1);
                        end
                        match_cnt_d = 4'd0;
                        state_d     = ST_SYNC;
                    end
                end
                default: begin
                    match_cnt_d = 4'd0;
                    state_d     = ST_IDLE;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            prev_val_q  <= '0;
            prev_dir_q  <= 1'b0;
            match_cnt_q <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            last_val_q  <= '0;
        end else begin
            state_q     <= state_d;
            prev_val_q  <= prev_val_d;
            prev_dir_q  <= prev_dir_d;
            match_cnt_q <= match_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            last_val_q  <= last_val_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign last_q    = last_val_q;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_checker.sv
// ============================================================================
// Module      : tb_count_seq_checker
// Description : Directed and randomized checks of count_seq_checker against a
//               behavioural sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_seq_checker;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 3;
    localparam int ERR_W    = 8;
    localparam int MODV     = 1 << WIDTH;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] q_in = '0;
    logic             dir_in = 1'b0;
    logic             clr_err = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] last_q;

    int checks   = 0;
    int failures = 0;

    // Reference model: history of the previous sample and the length of the
    // current run of correct predictions.
    bit m_started;
    int m_prev;
    bit m_prev_dir;
    int m_run;
    bit m_locked;
    bit m_pulse;
    int m_errs;
    int m_last;

    count_seq_checker #(
        .WIDTH   (WIDTH),
        .LOCK_CNT(LOCK_CNT),
        .ERR_W   (ERR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .q_in     (q_in),
        .dir_in   (dir_in),
        .clr_err  (clr_err),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .last_q   (last_q)
    );

    always #5 clk = ~clk;

    function automatic int predict();
        return (m_prev + (m_prev_dir ? MODV - 1 : 1)) % MODV;
    endfunction

    function automatic void model_reset();
        m_started  = 0;
        m_prev     = 0;
        m_prev_dir = 0;
        m_run      = 0;
        m_locked   = 0;
        m_pulse    = 0;
        m_errs     = 0;
        m_last     = 0;
    endfunction

    function automatic void model_sample(bit e, int q, bit d, bit c);
        m_pulse = 0;
        if (c) m_errs = 0;
        if (e) begin
            if (!m_started) begin
                m_started = 1;
                m_run     = 0;
            end else if (q == predict()) begin
                if (!m_locked) begin
                    m_run = m_run + 1;
                    if (m_run == LOCK_CNT) m_locked = 1;
                end
            end else begin
                if (m_locked) begin
                    m_pulse  = 1;
                    m_errs   = (m_errs < ERR_MAX) ? m_errs + 1 : ERR_MAX;
                    m_locked = 0;
                end
                m_run = 0;
            end
            m_prev     = q;
            m_prev_dir = d;
            m_last     = q;
        end
    endfunction

    function automatic void chk(string tag, int act, int exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endfunction

    function automatic void chk_all(string tag);
        chk({tag, ".locked"},    int'(locked),    int'(m_locked));
        chk({tag, ".err_pulse"}, int'(err_pulse), int'(m_pulse));
        chk({tag, ".err_count"}, int'(err_count), m_errs);
        chk({tag, ".last_q"},    int'(last_q),    m_last);
    endfunction

    task automatic step(input bit e, input int q, input bit d, input bit c, input string tag);
        @(negedge clk);
        en      = e;
        q_in    = WIDTH'(q);
        dir_in  = d;
        clr_err = c;
        @(posedge clk);
        model_sample(e, q, d, c);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset   = 1'b0;
        en      = 1'b1;
        clr_err = 1'b1;
        q_in    = WIDTH'($urandom_range(0, MODV - 1));
        @(posedge clk);
        model_reset();
        #1;
        chk_all(tag);
        @(negedge clk);
        reset   = 1'b1;
        en      = 1'b0;
        clr_err = 1'b0;
    endtask

    // n correct steps continuing in direction d
    task automatic good_steps(input int n, input bit d, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, predict(), d, 1'b0, tag);
    endtask

    task automatic bad_step(input bit c, input string tag);
        step(1'b1, (predict() + 5) % MODV, 1'b0, c, tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset0");
        do_reset("reset1");

        // Lock going up from 3
        step(1, 3, 0, 0, "up_cap");
        step(1, 4, 0, 0, "up4");
        step(1, 5, 0, 0, "up5");
        chk("up5.not_locked", int'(locked), 0);
        step(1, 6, 0, 0, "up6");
        chk("up6.locked", int'(locked), 1);

        // Up wrap 15 -> 0
        do_reset("reset_wrap");
        step(1, 11, 0, 0, "w11");
        step(1, 12, 0, 0, "w12");
        step(1, 13, 0, 0, "w13");
        step(1, 14, 0, 0, "w14");
        step(1, 15, 0, 0, "w15");
        step(1, 0,  0, 0, "w0");
        step(1, 1,  0, 0, "w1");
        chk("wrap.locked", int'(locked), 1);

        // Down wrap with direction change at 15
        do_reset("reset_down");
        step(1, 3,  1, 0, "d3");
        step(1, 2,  1, 0, "d2");
        step(1, 1,  1, 0, "d1");
        step(1, 0,  1, 0, "d0");
        step(1, 15, 0, 0, "d15");
        step(1, 0,  0, 0, "dc0");
        step(1, 1,  0, 0, "dc1");
        chk("dirchg.locked", int'(locked), 1);
        chk("dirchg.errs", int'(err_count), 0);

        // Injected error: 9 where 5 expected
        do_reset("reset_inj");
        step(1, 1, 0, 0, "i1");
        step(1, 2, 0, 0, "i2");
        step(1, 3, 0, 0, "i3");
        step(1, 4, 0, 0, "i4");
        step(1, 9, 0, 0, "inj9");
        chk("inj.pulse", int'(err_pulse), 1);
        chk("inj.count", int'(err_count), 1);
        chk("inj.locked", int'(locked), 0);
        step(1, 10, 0, 0, "i10");
        chk("inj.pulse_gone", int'(err_pulse), 0);
        step(1, 11, 0, 0, "i11");
        step(1, 12, 0, 0, "i12");
        chk("relock", int'(locked), 1);

        // Held value while locked is a mismatch
        step(1, 12, 0, 0, "hold");
        chk("hold.pulse", int'(err_pulse), 1);

        // en=0 gap while locked
        good_steps(3, 0, "pre_gap");
        for (int i = 0; i < 5; i++)
            step(0, $urandom_range(0, MODV - 1), 1'($urandom_range(0, 1)), 0, "gap");
        chk("gap.locked", int'(locked), 1);
        good_steps(2, 0, "post_gap");
        chk("post_gap.locked", int'(locked), 1);

        // Build err_count to 7, then clear coincident with a mismatch
        do_reset("reset_clr");
        step(1, 0, 0, 0, "c_cap");
        for (int k = 0; k < 7; k++) begin
            good_steps(LOCK_CNT, 0, "c_lock");
            bad_step(0, "c_bad");
        end
        chk("clr.pre7", int'(err_count), 7);
        good_steps(LOCK_CNT, 0, "c_lock8");
        bad_step(1, "clr_bad");
        chk("clr.result1", int'(err_count), 1);

        // Saturation of err_count
        for (int k = 0; k < ERR_MAX + 3; k++) begin
            good_steps(LOCK_CNT, 0, "s_lock");
            bad_step(0, "s_bad");
        end
        chk("sat.count", int'(err_count), ERR_MAX);

        // Reset mid-lock
        good_steps(LOCK_CNT, 0, "r_lock");
        do_reset("reset_mid");
        chk("mid.locked", int'(locked), 0);
        chk("mid.count", int'(err_count), 0);
        step(1, 7, 1, 0, "mid_cap");
        chk("mid_cap.pulse", int'(err_pulse), 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit e, d, c;
            int q;
            e = ($urandom_range(0, 9) < 8);
            d = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 19) == 0);
            if (m_started && $urandom_range(0, 9) < 8) q = predict();
            else q = $urandom_range(0, MODV - 1);
            step(e, q, d, c, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
